md_issue_ctrl: RTL and testbench
================================

# md_issue_ctrl

Issue and interlock controller for the multiply/divide unit (MDU) in the five-stage pipeline. It sits in the EX stage and receives the decoded MDU operation class of the EX instruction. It issues the one-cycle start pulse and the mthi/mtlo write strobes to the MDU. It mirrors the MDU's busy window with its own down-counter and drives the D-stage stall for any MDU-class instruction that would otherwise enter EX while the unit is occupied.

## Interface
Parameters:
- MULT_LAT, 5, cycles busy is high after a mult/multu start (legal 1..15)
- DIV_LAT, 10, cycles busy is high after a div/divu start (legal 1..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- e_valid  in  1  EX holds a real (non-bubble) instruction
- e_md_op  in  3  EX op class: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- e_flush  in  1  exception/interrupt cancels the EX instruction this cycle
- e_rt_val  in  32  forwarded rt operand of EX instruction (divisor)
- d_md_use  in  1  D-stage instruction is any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- md_start  out  1  combinational start pulse to MDU
- md_op  out  3  e_md_op passed through, qualified with md_start/md_wr_*
- md_wr_hi  out  1  combinational mthi write strobe
- md_wr_lo  out  1  combinational mtlo write strobe
- busy  out  1  registered; MDU result not yet in HI/LO
- stall  out  1  combinational D-stage stall request
- proto_err  out  1  sticky registered flag: MDU op reached EX while busy

## Operation
- FSM states IDLE, RUN. 4-bit counter cnt; busy = (state == RUN).
- issue_ok = e_valid & !e_flush.
- IDLE, issue_ok, op in 1..4: md_start=1; cnt <= MULT_LAT (ops 1,2) or DIV_LAT (ops 3,4); next RUN.
- RUN: cnt <= cnt-1 each cycle; when cnt==1, next IDLE and cnt <= 0.
- op 5/6 with issue_ok and state IDLE: md_wr_hi/md_wr_lo=1 for one cycle; no state change.
- e_flush=1: suppresses md_start, md_wr_hi and md_wr_lo that cycle. It never aborts an op already in RUN, because the MDU cannot cancel.
- stall = d_md_use & (busy | md_start).
- Op 1..6 with e_valid & !e_flush while in RUN: no start, no write strobe, proto_err <= 1. The FSM keeps counting. proto_err clears only on reset.
- Op 0 or 7: no action.

## Timing
- Reset values: state IDLE, cnt 0, busy 0, proto_err 0. Combinational outputs md_start, md_wr_hi, md_wr_lo and stall are 0 whenever inputs are idle.
- Start at edge-cycle t means md_start is high in cycle t. busy is high in cycles t+1..t+LAT and low in t+LAT+1. This matches the MDU's own busy window exactly.
- A D-stage MDU instruction stalls in cycles t..t+LAT and advances in t+LAT+1.
- Back-to-back starts are possible: a new start can occur in the first cycle busy is low.
- Reset asserted mid-RUN: IDLE and busy=0 on the next edge; outstanding count discarded.
- Start and flush in the same cycle: flush wins; state stays IDLE.

## Configuration
- MD_DIV0_SKIP_EN defined: div/divu with e_rt_val == 0 is treated as op none. There is no md_start, no busy, no stall, and HI/LO are left unchanged.
- Not defined: a zero-divisor div/divu is issued normally with DIV_LAT.

## Test plan
- Reset, then mult in EX at cycle 2 with d_md_use=1 -> md_start high in cycle 2; busy high in cycles 3..7; stall high in 2..7; low from cycle 8.
- div issued, then a second div presented when busy falls -> second md_start in cycle t+11; busy continuous except one low cycle at t+11.
- mult in EX with e_flush=1 -> md_start=0, busy stays 0, stall=0.
- mthi while IDLE -> md_wr_hi=1 for 1 cycle. Force mtlo while RUN -> md_wr_lo=0 and proto_err=1 until reset.
- divu with e_rt_val=0 -> with MD_DIV0_SKIP_EN: no start, busy 0. Without it: start, busy for 10 cycles.
- reset asserted in cycle 3 of a div -> busy=0 next cycle; subsequent mult behaves as from reset.

Source files
------------

// File: rtl/md_issue_ctrl_if.sv
// md_issue_ctrl_if: EX-stage handshake between the pipeline and the MDU issue controller.
// The master is the pipeline and MDU side. The slave is md_issue_ctrl.
interface md_issue_ctrl_if;
  logic        e_valid;
  logic [2:0]  e_md_op;
  logic        e_flush;
  logic [31:0] e_rt_val;
  logic        d_md_use;
  logic        md_start;
  logic [2:0]  md_op;
  logic        md_wr_hi;
  logic        md_wr_lo;
  logic        busy;
  logic        stall;
  logic        proto_err;

  modport master (
    output e_valid, e_md_op, e_flush, e_rt_val, d_md_use,
    input  md_start, md_op, md_wr_hi, md_wr_lo, busy, stall, proto_err
  );

  modport slave (
    input  e_valid, e_md_op, e_flush, e_rt_val, d_md_use,
    output md_start, md_op, md_wr_hi, md_wr_lo, busy, stall, proto_err
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issues MDU start pulses and mthi/mtlo strobes, tracks the MDU busy
// window with a down-counter, and stalls MDU-class instructions in the D stage.
// Optional feature macro MD_DIV0_SKIP_EN: div/divu with a zero divisor is treated as no-op.
module md_issue_ctrl #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic clk,
  input  logic reset,
  md_issue_ctrl_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

`ifdef MD_DIV0_SKIP_EN
  localparam logic DIV0_SKIP = 1'b1;
`else
  localparam logic DIV0_SKIP = 1'b0;
`endif

  localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

  state_t      r_state;
  state_t      w_nextState;
  logic [3:0]  r_cnt;
  logic [3:0]  w_nextCnt;
  logic        r_protoErr;

  logic        w_issueOk;
  logic        w_isDiv;
  logic        w_rtZero;
  logic        w_skipOp;
  logic [2:0]  w_op;
  logic        w_opArith;
  logic        w_opMult;
  logic        w_opHi;
  logic        w_opLo;
  logic        w_start;
  logic        w_wrHi;
  logic        w_wrLo;

  // Decode the effective operation: reserved and skipped zero-divisor divides become none
  always_comb begin
    w_issueOk = bus.e_valid & ~bus.e_flush;
    w_isDiv   = (bus.e_md_op == 3'd3) | (bus.e_md_op == 3'd4);
    w_rtZero  = (bus.e_rt_val == 32'd0);
    w_skipOp  = DIV0_SKIP & w_isDiv & w_rtZero;
    w_op      = bus.e_md_op;
    if (bus.e_md_op == 3'd7 || w_skipOp) begin
      w_op = 3'd0;
    end
    w_opArith = (w_op >= 3'd1) && (w_op <= 3'd4);
    w_opMult  = (w_op == 3'd1) || (w_op == 3'd2);
    w_opHi    = (w_op == 3'd5);
    w_opLo    = (w_op == 3'd6);
  end

  // State and busy-window counter register; reset discards any outstanding count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  // Next-state logic: load latency on a start, count down in RUN, leave after the last busy cycle
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_issueOk && w_opArith) begin
          w_nextState = RUN;
          w_nextCnt   = w_opMult ? MULT_CNT : DIV_CNT;
        end
      end
      RUN: begin
        if (r_cnt == 4'd1) begin
          w_nextState = IDLE;
          w_nextCnt   = 4'd0;
        end else begin
          w_nextCnt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextCnt   = 4'd0;
      end
    endcase
  end

  // Output logic: strobes only fire from IDLE, and stall covers the start cycle plus the busy window
  always_comb begin
    w_start      = w_issueOk & w_opArith & (r_state == IDLE);
    w_wrHi       = w_issueOk & w_opHi & (r_state == IDLE);
    w_wrLo       = w_issueOk & w_opLo & (r_state == IDLE);
    bus.md_start = w_start;
    bus.md_wr_hi = w_wrHi;
    bus.md_wr_lo = w_wrLo;
    bus.md_op    = (w_start | w_wrHi | w_wrLo) ? bus.e_md_op : 3'd0;
    bus.busy     = (r_state == RUN);
    bus.stall    = bus.d_md_use & ((r_state == RUN) | w_start);
    bus.proto_err = r_protoErr;
  end

  // Sticky protocol error: an MDU op reached EX while the unit was still running
  always_ff @(posedge clk) begin
    if (reset) begin
      r_protoErr <= 1'b0;
    end else if (w_issueOk && (r_state == RUN) && (w_op != 3'd0)) begin
      r_protoErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: directed and randomized bench for md_issue_ctrl.
// The reference model tracks the cycle number of the last start and the latency of that start.
module tb_md_issue_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

`ifdef MD_DIV0_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int lastStart = -1000;
  int lastLat   = 0;
  bit errFlag   = 1'b0;
  int n;

  md_issue_ctrl_if mif();

  md_issue_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif.slave)
  );

  // Free-running clock with a 10-unit period
  always #5 clk = ~clk;

  // Compare one observed value against the expected value and log any mismatch
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check all outputs against the model, then advance one clock
  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic fl,
                               input logic [31:0] rt, input logic du, input logic rst);
    logic       busyNow;
    logic       issueOk;
    logic [2:0] effOp;
    logic       expStart;
    logic       expHi;
    logic       expLo;
    logic [2:0] expOp;
    logic       expStall;
    reset        = rst;
    mif.e_valid  = v;
    mif.e_md_op  = op;
    mif.e_flush  = fl;
    mif.e_rt_val = rt;
    mif.d_md_use = du;
    #1;
    busyNow = (cyc >= lastStart + 1) && (cyc <= lastStart + lastLat);
    issueOk = v && !fl;
    effOp   = (op == 3'd7) ? 3'd0 : op;
    if (SKIP && (op == 3'd3 || op == 3'd4) && rt == 32'd0) effOp = 3'd0;
    expStart = issueOk && !busyNow && effOp >= 3'd1 && effOp <= 3'd4;
    expHi    = issueOk && !busyNow && effOp == 3'd5;
    expLo    = issueOk && !busyNow && effOp == 3'd6;
    expOp    = (expStart || expHi || expLo) ? op : 3'd0;
    expStall = du && (busyNow || expStart);
    checkOutput("md_start", {31'd0, mif.md_start}, {31'd0, expStart});
    checkOutput("md_wr_hi", {31'd0, mif.md_wr_hi}, {31'd0, expHi});
    checkOutput("md_wr_lo", {31'd0, mif.md_wr_lo}, {31'd0, expLo});
    checkOutput("md_op", {29'd0, mif.md_op}, {29'd0, expOp});
    checkOutput("busy", {31'd0, mif.busy}, {31'd0, busyNow});
    checkOutput("stall", {31'd0, mif.stall}, {31'd0, expStall});
    checkOutput("proto_err", {31'd0, mif.proto_err}, {31'd0, errFlag});
    if (rst) begin
      lastStart = -1000;
      errFlag   = 1'b0;
    end else begin
      if (issueOk && busyNow && effOp != 3'd0) errFlag = 1'b1;
      if (expStart) begin
        lastStart = cyc;
        lastLat   = (effOp <= 3'd2) ? MULT_LAT : DIV_LAT;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Directed scenarios followed by a randomized run
  initial begin
    reset        = 1'b1;
    mif.e_valid  = 1'b0;
    mif.e_md_op  = 3'd0;
    mif.e_flush  = 1'b0;
    mif.e_rt_val = 32'd0;
    mif.d_md_use = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    cyc = 0;

    // Reset state, then mult at cycle 2 with a waiting D-stage MDU instruction
    applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd1, 1'b0, 32'd3, 1'b1, 1'b0);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (mif.busy === 1'b1) n++;
      applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    end
    checkOutput("multBusyLen", n, MULT_LAT);

    // Back-to-back divides: the second is presented in the first non-busy cycle
    applyStimulus(1'b1, 3'd3, 1'b0, 32'd7, 1'b1, 1'b0);
    for (int i = 0; i < DIV_LAT; i++) applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 3'd3, 1'b0, 32'd9, 1'b1, 1'b0);
    for (int i = 0; i < DIV_LAT + 2; i++) applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 1'b0, 1'b0);

    // Flushed mult never starts
    applyStimulus(1'b1, 3'd1, 1'b1, 32'd1, 1'b1, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 1'b1, 1'b0);

    // mthi while idle, then mtlo while running sets the sticky error
    applyStimulus(1'b1, 3'd5, 1'b0, 32'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd2, 1'b0, 32'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd6, 1'b0, 32'd1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 1'b0, 1'b0);

    // divu with a zero divisor
    applyStimulus(1'b1, 3'd4, 1'b0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < DIV_LAT + 2; i++) applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 1'b1, 1'b0);

    // Reset during the third busy cycle of a div, then a fresh mult
    applyStimulus(1'b1, 3'd3, 1'b0, 32'd5, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 1'b1, 1'b1);
    applyStimulus(1'b1, 3'd1, 1'b0, 32'd5, 1'b1, 1'b0);
    for (int i = 0; i < MULT_LAT + 2; i++) applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 1'b1, 1'b0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic [2:0]  op;
      logic [31:0] rt;
      op = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      rt = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
      applyStimulus(1'($urandom_range(0, 3) != 0), op, 1'($urandom_range(0, 7) == 0),
                    rt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
